// File: rtl/deskew_ctrl.sv
// deskew_ctrl: multi-lane deskew calibration controller.
// Measures each lane's alignment-marker arrival relative to the earliest
// lane. From that it derives per-lane delay selects that align every lane to
// the latest one. Selects are committed only after enough consecutive
// identical measurements.
`timescale 1ns/1ps
module deskew_ctrl #(
  parameter int LANES    = 4,
  parameter int MAX_DLY  = 3,
  parameter int SEL_W    = $clog2(MAX_DLY + 1),
  parameter int LOCK_CNT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [LANES-1:0]       marker,
  output logic [LANES*SEL_W-1:0] sel,
  output logic                   sel_upd,
  output logic                   locked,
  output logic                   busy,
  output logic                   meas_err
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [SEL_W-1:0] MAX_K    = SEL_W'(MAX_DLY);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WIN,
    S_EVAL
  } state_t;

  state_t state, next_state;

  logic [SEL_W-1:0]       cnt;
  logic [SEL_W-1:0]       win_k;
  logic [LANES-1:0]       seen;
  logic                   dup;
  logic [LANES*SEL_W-1:0] off;
  logic [LANES*SEL_W-1:0] cand;
  logic [MW-1:0]          match;

  logic [SEL_W-1:0]       max_off;
  logic [LANES*SEL_W-1:0] dly;
  logic                   win_ok;
  logic [MW-1:0]          match_next;
  logic                   lock_hit;

  assign win_k = cnt + 1'b1;
  assign busy  = (state != S_IDLE);

  // State register; reset lands in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; stop overrides everything, including start.
  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start)   next_state = S_WAIT;
        S_WAIT: if (|marker) next_state = S_WIN;
        S_WIN:  if (win_k == MAX_K) next_state = S_EVAL;
        S_EVAL: next_state = S_WAIT;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Window evaluation: delays toward the latest lane, validity and match count.
  always_comb begin
    max_off = '0;
    for (int i = 0; i < LANES; i++) begin
      if (off[i*SEL_W +: SEL_W] > max_off) max_off = off[i*SEL_W +: SEL_W];
    end
    dly = '0;
    for (int i = 0; i < LANES; i++) begin
      dly[i*SEL_W +: SEL_W] = max_off - off[i*SEL_W +: SEL_W];
    end
    win_ok = (&seen) && !dup;
    if (dly == cand) begin
      match_next = (match == LOCK_MAX) ? match : match + 1'b1;
    end else begin
      match_next = MW'(1);
    end
    lock_hit = (match_next == LOCK_MAX);
  end

  // Window capture, candidate tracking and registered output updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      seen     <= '0;
      dup      <= 1'b0;
      off      <= '0;
      cand     <= '0;
      match    <= '0;
      sel      <= '0;
      sel_upd  <= 1'b0;
      locked   <= 1'b0;
      meas_err <= 1'b0;
    end else begin
      sel_upd  <= 1'b0;
      meas_err <= 1'b0;
      if (stop) begin
        locked <= 1'b0;
        match  <= '0;
        cnt    <= '0;
        seen   <= '0;
        dup    <= 1'b0;
        off    <= '0;
      end else begin
        case (state)
          S_WAIT: begin
            if (|marker) begin
              seen <= marker;
              dup  <= 1'b0;
              off  <= '0;
              cnt  <= '0;
            end
          end
          S_WIN: begin
            cnt <= win_k;
            for (int i = 0; i < LANES; i++) begin
              if (marker[i]) begin
                if (seen[i]) begin
                  dup <= 1'b1;
                end else begin
                  seen[i]                 <= 1'b1;
                  off[i*SEL_W +: SEL_W]   <= win_k;
                end
              end
            end
          end
          S_EVAL: begin
            if (!win_ok) begin
              meas_err <= 1'b1;
              match    <= '0;
              locked   <= 1'b0;
            end else if (locked) begin
              if (dly != sel) begin
                locked <= 1'b0;
                cand   <= dly;
                match  <= MW'(1);
              end
            end else begin
              cand  <= dly;
              match <= match_next;
              if (lock_hit) begin
                sel     <= dly;
                locked  <= 1'b1;
                sel_upd <= (dly != sel);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
